// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider: one quotient bit per clock, WIDTH steps per divide.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (magnitude core plus sign fix-up).
module seq_divider #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] work_r;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] next_r;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dsr_mag;
    logic             last_step;
    logic             divisor_zero;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q;
    logic neg_r;
    assign dvd_mag = dividend[WIDTH-1] ? (WIDTH'(0) - dividend) : dividend;
    assign dsr_mag = divisor[WIDTH-1]  ? (WIDTH'(0) - divisor)  : divisor;
`else
    assign dvd_mag = dividend;
    assign dsr_mag = divisor;
`endif

    assign divisor_zero = (divisor == '0);
    assign last_step    = (cnt == CNT_W'(WIDTH - 1));

    // R < divisor always holds, so bit WIDTH of the trial difference is a clean borrow flag.
    assign trial  = {work_r, work_q[WIDTH-1]} - {1'b0, dsr};
    assign next_q = {work_q[WIDTH-2:0], ~trial[WIDTH]};
    assign next_r = trial[WIDTH] ? {work_r[WIDTH-2:0], work_q[WIDTH-1]} : trial[WIDTH-1:0];

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = divisor_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            work_q      <= '0;
            work_r      <= '0;
            dsr         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt         <= '0;
                        work_r      <= '0;
                        work_q      <= dvd_mag;
                        dsr         <= dsr_mag;
                        div_by_zero <= divisor_zero;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r       <= dividend[WIDTH-1];
`endif
                        // Divide by zero finishes on the capture edge itself.
                        if (divisor_zero) begin
                            quotient  <= '1;
                            remainder <= dividend;
                        end
                    end
                end
                CALC: begin
                    work_q <= next_q;
                    work_r <= next_r;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_step) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                        quotient  <= neg_q ? (WIDTH'(0) - next_q) : next_q;
                        remainder <= neg_r ? (WIDTH'(0) - next_r) : next_r;
`else
                        quotient  <= next_q;
                        remainder <= next_r;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed and random divides checked against a plain-arithmetic model.
module tb_seq_divider;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        int sa;
        int sb;
        sa = 0;
        sb = 0;
        if (b == '0) begin
            q = '1;
            r = a;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            sa = $signed(a);
            sb = $signed(b);
            q  = W'(sa / sb);
            r  = W'(sa % sb);
`else
            sa = int'(a);
            sb = int'(b);
            q  = W'(sa / sb);
            r  = W'(sa % sb);
`endif
        end
    endfunction

    // Called #1 after an edge with the DUT idle; returns #1 after the edge following done.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int repulse_at, input string tag);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic [W-1:0] held_q;
        logic [W-1:0] held_r;
        int           n;
        int           exp_lat;
        logic         stable;
        model(a, b, eq, er);
        exp_lat  = (b == '0) ? 1 : W + 1;
        held_q   = quotient;
        held_r   = remainder;
        stable   = 1'b1;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        n = 1;
        check({tag, ":busy_after_start"}, 32'(busy), 32'd1);
        while (!done && n < 4 * W) begin
            if (quotient !== held_q || remainder !== held_r) stable = 1'b0;
            if (n == repulse_at) begin
                start    = 1'b1;
                dividend = W'(200);
                divisor  = W'(3);
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        check({tag, ":latency"}, 32'(n), 32'(exp_lat));
        check({tag, ":done"}, 32'(done), 32'd1);
        check({tag, ":busy_in_done"}, 32'(busy), 32'd1);
        check({tag, ":quotient"}, 32'(quotient), 32'(eq));
        check({tag, ":remainder"}, 32'(remainder), 32'(er));
        check({tag, ":div_by_zero"}, 32'(div_by_zero), 32'(b == '0));
        check({tag, ":held_during_calc"}, 32'(stable), 32'd1);
        @(posedge clk); #1;
        check({tag, ":done_one_cycle"}, 32'(done), 32'd0);
        check({tag, ":busy_cleared"}, 32'(busy), 32'd0);
        check({tag, ":quotient_held"}, 32'(quotient), 32'(eq));
        check({tag, ":remainder_held"}, 32'(remainder), 32'(er));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset:busy", 32'(busy), 32'd0);
        check("reset:done", 32'(done), 32'd0);
        check("reset:quotient", 32'(quotient), 32'd0);
        check("reset:remainder", 32'(remainder), 32'd0);
        check("reset:div_by_zero", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_div(W'(100), W'(7), 0, "d100_7");
`ifndef SEQ_DIVIDER_SIGNED_EN
        check("d100_7:const_q", 32'(quotient), 32'd14);
        check("d100_7:const_r", 32'(remainder), 32'd2);
`endif
        run_div(W'(255), W'(1), 0, "d255_1");
        run_div(W'(5), W'(9), 0, "d5_9");
        run_div(W'(37), W'(0), 0, "d37_0");
        run_div(W'(100), W'(7), 3, "repulse");
        run_div(W'(0), W'(5), 0, "d0_5");
        run_div(W'(255), W'(255), 0, "d255_255");

`ifdef SEQ_DIVIDER_SIGNED_EN
        run_div(W'(156), W'(7), 0, "neg100_7");
        check("neg100_7:const_q", 32'(quotient), 32'hF2);
        check("neg100_7:const_r", 32'(remainder), 32'hFE);
        run_div(W'(128), W'(255), 0, "neg128_neg1");
        check("neg128_neg1:const_q", 32'(quotient), 32'h80);
        check("neg128_neg1:const_r", 32'(remainder), 32'h00);
`endif

        // Asynchronous reset landing between edges in the middle of a divide.
        run_div(W'(100), W'(7), 0, "pre_reset");
        dividend = W'(50);
        divisor  = W'(7);
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1;
        #1;
        check("async_rst:busy", 32'(busy), 32'd0);
        check("async_rst:done", 32'(done), 32'd0);
        check("async_rst:quotient", 32'(quotient), 32'd0);
        check("async_rst:remainder", 32'(remainder), 32'd0);
        check("async_rst:div_by_zero", 32'(div_by_zero), 32'd0);
        #1;
        rst = 1'b0;
        repeat (W + 2) begin
            @(posedge clk); #1;
        end
        check("async_rst:no_done", 32'(done), 32'd0);
        check("async_rst:idle", 32'(busy), 32'd0);
        run_div(W'(9), W'(3), 0, "d9_3");

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 9) == 0) ? W'(0) : W'($urandom);
            run_div(ra, rb, 0, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
